// File: rtl/fpu_add_sequencer.sv
// Multi-cycle double-precision adder: IDLE -> ALIGN -> ADD -> NORM (iterative) -> DONE.
// Truncating, no special-case handling of Inf/NaN inputs; subnormal inputs read as zero.
module fpu_add_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      a,
  input  logic [63:0]      b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      result,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StAlign = 3'd1;
  localparam logic [2:0] StAdd   = 3'd2;
  localparam logic [2:0] StNorm  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [63:0]      a_q, a_d, b_q, b_d;
  logic [10:0]      exp_q, exp_d;
  logic             s1_q, s1_d, s2_q, s2_d;
  logic [52:0]      m1_q, m1_d, m2_q, m2_d;
  logic [53:0]      sum_q, sum_d;
  logic             sign_q, sign_d;
  logic [63:0]      result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Alignment datapath, only meaningful in StAlign.
  logic [10:0] ea, eb, diff;
  logic [52:0] ma, mb, m_small;
  logic        a_big;

  always_comb begin
    ea      = a_q[62:52];
    eb      = b_q[62:52];
    ma      = (ea == 11'd0) ? 53'd0 : {1'b1, a_q[51:0]};
    mb      = (eb == 11'd0) ? 53'd0 : {1'b1, b_q[51:0]};
    a_big   = (ea >= eb);
    diff    = a_big ? (ea - eb) : (eb - ea);
    m_small = a_big ? mb : ma;
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign op_count  = cnt_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    exp_d       = exp_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    m1_d        = m1_q;
    m2_d        = m2_q;
    sum_d       = sum_q;
    sign_d      = sign_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          state_d = StAlign;
        end
      end
      StAlign: begin
        exp_d   = a_big ? ea : eb;
        s1_d    = a_big ? a_q[63] : b_q[63];
        s2_d    = a_big ? b_q[63] : a_q[63];
        m1_d    = a_big ? ma : mb;
        m2_d    = (diff >= 11'd53) ? 53'd0 : (m_small >> diff);
        state_d = StAdd;
      end
      StAdd: begin
        if (s1_q == s2_q) begin
          sum_d  = {1'b0, m1_q} + {1'b0, m2_q};
          sign_d = s1_q;
        end else if (m1_q >= m2_q) begin
          sum_d  = {1'b0, m1_q} - {1'b0, m2_q};
          sign_d = s1_q;
        end else begin
          sum_d  = {1'b0, m2_q} - {1'b0, m1_q};
          sign_d = s2_q;
        end
        state_d = StNorm;
      end
      StNorm: begin
        // One normalisation step per cycle; terminal cases jump straight to DONE.
        if (sum_q == 54'd0) begin
          result_d    = 64'h0;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else if (exp_q == 11'h7FF) begin
          result_d    = {sign_q, 11'h7FF, 52'h0};
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else if (exp_q == 11'd0) begin
          result_d    = {sign_q, 63'h0};
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else if (sum_q[53]) begin
          sum_d = sum_q >> 1;
          exp_d = exp_q + 11'd1;
        end else if (!sum_q[52]) begin
          sum_d = sum_q << 1;
          exp_d = exp_q - 11'd1;
        end else begin
          result_d    = {sign_q, exp_q, sum_q[51:0]};
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= 64'h0;
      b_q         <= 64'h0;
      exp_q       <= 11'h0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      m1_q        <= 53'h0;
      m2_q        <= 53'h0;
      sum_q       <= 54'h0;
      sign_q      <= 1'b0;
      result_q    <= 64'h0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      exp_q       <= exp_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      m1_q        <= m1_d;
      m2_q        <= m2_d;
      sum_q       <= sum_d;
      sign_q      <= sign_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fpu_add_sequencer.sv
// Directed bench for fpu_add_sequencer: scoreboard of expected sums and arrival cycles.
module tb_fpu_add_sequencer;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      a;
  logic [63:0]      b;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      result;
  logic [CNT_W-1:0] op_count;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          exp_cnt = 0;
  logic [63:0] q_res[$];
  int          q_due[$];

  fpu_add_sequencer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .op_count  (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [63:0] av, input logic [63:0] bv,
                      input logic [63:0] expv, input int lat);
    int n = 0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
    end else begin
      q_res.push_back(expv);
      q_due.push_back(cyc + lat);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int hold);
    int          n = 0;
    logic [63:0] expv;
    int          due;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid || q_res.size() == 0) begin
      chk({tag, "_out_valid_timeout"}, 64'(out_valid), 64'd1);
      q_res.delete();
      q_due.delete();
      return;
    end
    expv = q_res.pop_front();
    due  = q_due.pop_front();
    chk({tag, "_latency"}, 64'(cyc), 64'(due));
    chk({tag, "_result"}, result, expv);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_result"}, result, expv);
      chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_hold_count"}, 64'(op_count), 64'(exp_cnt));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt++;
    chk({tag, "_count"}, 64'(op_count), 64'(exp_cnt));
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 64'h0;
    b         = 64'h0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'h0);
    chk("rst_count", 64'(op_count), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    send(64'h3FF0000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 5);
    collect("one_plus_one", 0);
    send(64'h3FF0000000000000, 64'hBFF0000000000000, 64'h0000000000000000, 4);
    collect("one_minus_one", 0);
    send(64'h3FF8000000000000, 64'hBFF0000000000000, 64'h3FE0000000000000, 5);
    collect("onehalf_minus_one", 0);
    send(64'h3FF0000000000000, 64'h3C30000000000000, 64'h3FF0000000000000, 4);
    collect("big_shift", 0);
    send(64'h4000000000000000, 64'h4008000000000000, 64'h4014000000000000, 5);
    collect("two_plus_three", 0);
    send(64'h3FF0000000000000, 64'h3FE0000000000000, 64'h3FF8000000000000, 4);
    collect("one_plus_half", 0);
    send(64'h3FE0000000000000, 64'hBFF0000000000000, 64'hBFE0000000000000, 5);
    collect("half_minus_one", 0);
    send(64'hBFF0000000000000, 64'hBFF0000000000000, 64'hC000000000000000, 5);
    collect("neg_plus_neg", 0);
    send(64'h3FF0000000000000, 64'hBFE8000000000000, 64'h3FD0000000000000, 6);
    collect("two_left_shifts", 0);

    send(64'h3FF0000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 5);
    collect("stall", 10);

    // Abort in NORM: the operation below needs two left shifts.
    send(64'h3FF0000000000000, 64'hBFE8000000000000, 64'h3FD0000000000000, 6);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_res.delete();
    q_due.delete();
    exp_cnt = 0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_count", 64'(op_count), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 64'(out_valid), 64'd0);
    end
    send(64'h3FF0000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 5);
    collect("after_abort", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_add_sequencer.md
FPU_ADD_SEQUENCER -- requirements
Module: fpu_add_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, operand pair a/b is valid.
REQ-005 SHALL have port in_ready, output, 1, sequencer accepts an operand pair.
REQ-006 SHALL have port a, input, 64, IEEE-754 double operand A.
REQ-007 SHALL have port b, input, 64, IEEE-754 double operand B.
REQ-008 SHALL have port out_valid, output, 1, result is valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port result, output, 64, the double-precision sum a+b.
REQ-011 SHALL have port op_count, output, CNT_W, number of completed result handshakes.

Function
REQ-012 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, DONE, one state per cycle.
REQ-013 SHALL drive in_ready=1 only in IDLE with rst low; input handshake = in_valid & in_ready captures a, b and moves to ALIGN.
REQ-014 ALIGN SHALL treat an exponent-0 operand as zero (hidden bit 0, mantissa 0); otherwise the mantissa is {1, frac} (53 bits).
REQ-015 ALIGN SHALL select operand 1 = a when exp_a >= exp_b (tie selects a), else b; register the big exponent, both signs, and mantissa2 >> |exp_a - exp_b|; shifts >= 53 give 0; then go to ADD.
REQ-016 ADD SHALL form a 54-bit sum: equal signs -> m1+m2 with sign1; differing signs -> larger minus smaller magnitude with the larger operand's sign; then go to NORM.
REQ-017 NORM SHALL do one action per cycle, in priority order: sum==0 -> result 64'h0 and go to DONE; sum[53]=1 -> shift right 1, exp+1; sum[52]=0 -> shift left 1, exp-1; else pack {sign, exp, sum[51:0]} and go to DONE.
REQ-018 Rounding SHALL be truncation: bits lost in alignment and right shift are discarded.
REQ-019 If exp reaches 2047 in NORM, the result SHALL be {sign, 11'h7FF, 52'h0} and the FSM goes to DONE.
REQ-020 If exp reaches 0 in NORM, the result SHALL flush to {sign, 63'h0} and the FSM goes to DONE.
REQ-021 Input exponent 2047 (Inf/NaN) SHALL NOT be specially handled; behaviour follows REQ-014..020.
REQ-022 DONE SHALL hold out_valid=1 with result stable until out_ready=1; on the handshake, op_count increments (wrapping at 2^CNT_W) and the FSM returns to IDLE.
REQ-023 Latency: accept in cycle T -> out_valid first high in cycle T+4+k, k = number of NORM shifts (0..53).
REQ-024 in_ready SHALL stay 0 from ALIGN through the DONE handshake; no second operation is accepted while one is in flight.
REQ-025 result, out_valid and op_count SHALL be registered outputs.

Reset
REQ-026 With rst high at a clock edge: state=IDLE, out_valid=0, result=0, op_count=0, internal datapath registers=0; in_ready=0 while rst is high.
REQ-027 Reset in any state SHALL abort the operation with no out_valid pulse; in_ready=1 in the first cycle after rst falls.

Verification
REQ-028 Bench: a=b=3FF0000000000000 -> result 4000000000000000, k=1, out_valid 5 cycles after accept.
REQ-029 Bench: a=3FF0000000000000, b=BFF0000000000000 -> result 0000000000000000, out_valid 4 cycles after accept.
REQ-030 Bench: a=3FF8000000000000, b=BFF0000000000000 -> result 3FE0000000000000 (k=1).
REQ-031 Bench: a=3FF0000000000000, b=3C30000000000000 (2^-60) -> result 3FF0000000000000 (shift >= 53).
REQ-032 Bench: out_ready held low 10 cycles in DONE -> result and out_valid stable, in_ready=0, op_count unchanged until the handshake, then +1.
REQ-033 Bench: rst pulsed during NORM -> no out_valid, op_count=0, next operation a=b=3FF0000000000000 completes correctly.
